sr_pulse_driver: RTL



---
 rtl/sr_pkg.sv | 23 ++
 rtl/sr_drv_timer.sv | 27 ++
 rtl/sr_pulse_driver.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared types, defaults and sizing helper for the SR pulse driver
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GUARD = 2'd2
    } sr_drv_state_t;

    localparam int   SR_PULSE_W_DEF = 1;
    localparam int   SR_GUARD_W_DEF = 1;
    localparam logic SR_RESET_Q     = 1'b1;

    // Counter must hold the larger of the two phase lengths; never narrower than 1 bit.
    function automatic int sr_cnt_width(input int pulse_w, input int guard_w);
        int max_w;
        int w;
        max_w = (pulse_w > guard_w) ? pulse_w : guard_w;
        w     = $clog2(max_w + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// rtl/sr_drv_timer.sv - loadable down-counter with zero flag, shared by PULSE and GUARD phases
module sr_drv_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/sr_pulse_driver.sv
// rtl/sr_pulse_driver.sv - turns set-level requests into S/R/en pulse sequences for an SR flop.
// Optional Q readback checking is built when SR_DRV_READBACK_EN is defined.
module sr_pulse_driver
    import sr_pkg::*;
#(
    parameter int   PULSE_W = SR_PULSE_W_DEF,
    parameter int   GUARD_W = SR_GUARD_W_DEF,
    parameter logic RESET_Q = SR_RESET_Q
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_val,
    input  logic req_force,
    output logic req_ready,
    output logic S,
    output logic R,
    output logic en,
    output logic q_shadow,
    output logic busy,
    output logic done
`ifdef SR_DRV_READBACK_EN
    ,
    input  logic q_fb,
    input  logic err_clr,
    output logic err
`endif
);

    localparam int            CW        = sr_cnt_width(PULSE_W, GUARD_W);
    localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GUARD_LD  = (GUARD_W > 0) ? CW'(GUARD_W - 1) : '0;
    localparam bit            HAS_GUARD = (GUARD_W > 0);

    sr_drv_state_t r_state;
    sr_drv_state_t w_state_nxt;
    logic          r_val;
    logic          r_q;
    logic          r_s;
    logic          r_r;
    logic          r_en;
    logic          r_busy;
    logic          r_done;

    logic          w_accept;
    logic          w_val_nxt;
    logic          w_q_nxt;
    logic          w_s_nxt;
    logic          w_r_nxt;
    logic          w_en_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_dec;
    logic          w_zero;

    // Held low during reset so upstream cannot see a ready driver before it is usable.
    assign req_ready = reset && (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;

    sr_drv_timer #(
        .W (CW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_val_nxt   = r_val;
        w_q_nxt     = r_q;
        w_s_nxt     = 1'b0;
        w_r_nxt     = 1'b0;
        w_en_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_dec       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!req_force && (req_val == r_q)) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_val_nxt   = req_val;
                        w_state_nxt = PULSE;
                        w_load      = 1'b1;
                        w_load_val  = PULSE_LD;
                        w_s_nxt     = req_val;
                        w_r_nxt     = !req_val;
                        w_en_nxt    = 1'b1;
                        w_busy_nxt  = 1'b1;
                    end
                end
            end
            PULSE: begin
                if (w_zero) begin
                    w_q_nxt = r_val;
                    if (HAS_GUARD) begin
                        w_state_nxt = GUARD;
                        w_load      = 1'b1;
                        w_load_val  = GUARD_LD;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_dec      = 1'b1;
                    w_s_nxt    = r_val;
                    w_r_nxt    = !r_val;
                    w_en_nxt   = 1'b1;
                    w_busy_nxt = 1'b1;
                end
            end
            GUARD: begin
                if (w_zero) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_dec      = 1'b1;
                    w_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_val   <= 1'b0;
            r_q     <= RESET_Q;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_val   <= w_val_nxt;
            r_q     <= w_q_nxt;
            r_s     <= w_s_nxt;
            r_r     <= w_r_nxt;
            r_en    <= w_en_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign S        = r_s;
    assign R        = r_r;
    assign en       = r_en;
    assign q_shadow = r_q;
    assign busy     = r_busy;
    assign done     = r_done;

`ifdef SR_DRV_READBACK_EN
    // Only a done that retires a real pulse is worth checking; skipped commands never touched the flop.
    logic r_done_pulsed;
    logic r_err;
    logic w_fb_mis;

    assign w_fb_mis = r_done_pulsed && (q_fb != r_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done_pulsed <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_done_pulsed <= w_done_nxt && (r_state != IDLE);
            r_err         <= w_fb_mis || (r_err && !err_clr);
        end
    end

    assign err = r_err;
`endif

endmodule
